// File: rtl/seg_bus_decoder_pkg.sv
// Shared definitions for the seven-segment bus monitor: glyph patterns,
// FSM encoding and bus field offsets.
package seg_bus_decoder_pkg;

  // bus field offsets
  localparam int EN_LSB = 8;
  localparam int DP_BIT = 7;

  // active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SCAN   = 2'd1,
    ST_ACCEPT = 2'd2
  } state_t;

endpackage

// File: rtl/seg_bus_decoder_glyph.sv
// Combinational seven-segment glyph decoder: active-low pattern to hex value.
// Blank and any non-hex pattern report legal = 0.
module seg7_glyph_decode
  import seg_bus_decoder_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       legal
);

  // table lookup; unknown patterns fall through as illegal
  always_comb begin
    val   = 4'h0;
    legal = 1'b1;
    case (pat)
      SEG_0: val = 4'h0;
      SEG_1: val = 4'h1;
      SEG_2: val = 4'h2;
      SEG_3: val = 4'h3;
      SEG_4: val = 4'h4;
      SEG_5: val = 4'h5;
      SEG_6: val = 4'h6;
      SEG_7: val = 4'h7;
      SEG_8: val = 4'h8;
      SEG_9: val = 4'h9;
      SEG_A: val = 4'hA;
      SEG_B: val = 4'hB;
      SEG_C: val = 4'hC;
      SEG_D: val = 4'hD;
      SEG_E: val = 4'hE;
      SEG_F: val = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_bus_decoder.sv
// Receive-side monitor for the multiplexed seven-segment bus. Synchronizes the
// bus, waits for a stable (digit, pattern) pair, decodes it and publishes
// per-digit value / dp / valid / error, plus frame and display-off status.
module seg_bus_decoder
  import seg_bus_decoder_pkg::*;
#(
  parameter int          NDIG       = 4,
  parameter int          STABLE_CNT = 4,
  parameter int          OFF_CNT    = 8,
  parameter int unsigned DIG_MASK   = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NDIG+7:0]      segf,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      dig_valid,
  output logic [NDIG-1:0]      dp,
  output logic [NDIG-1:0]      code_err,
  output logic                 frame_done,
  output logic                 disp_off
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [NDIG-1:0] MASK = DIG_MASK[NDIG-1:0];
  localparam logic [3:0]      STAB = 4'(STABLE_CNT);

  logic [NDIG+7:0] s1, s;
  state_t          state;
  logic [3:0]      stab_cnt, stab_nxt;
  logic [7:0]      off_cnt;
  logic            cand_vld;
  logic [KW-1:0]   cand_k;
  logic [7:0]      cand_pat;
  logic [NDIG-1:0] prog, prog_nxt;

  logic [NDIG-1:0] en_n;
  logic [CW-1:0]   zcnt;
  logic [KW-1:0]   dig_k;
  logic            dig_ok, same, fire, trip, frame_hit;
  logic [3:0]      g_val;
  logic            g_legal;

  assign en_n = s[EN_LSB +: NDIG];

  // count active (low) enables and remember which one; one-hot means a digit
  always_comb begin
    zcnt  = '0;
    dig_k = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!en_n[i]) begin
        zcnt  = zcnt + CW'(1);
        dig_k = KW'(i);
      end
    end
  end

  assign dig_ok = (zcnt == CW'(1));
  assign same   = cand_vld && dig_ok && (dig_k == cand_k) && (s[7:0] == cand_pat);
  assign trip   = (s == '0) && ((int'(off_cnt) + 1) >= OFF_CNT);

  // stability counter: saturate on a repeat, restart on change, clear on no-digit
  always_comb begin
    stab_nxt = '0;
    if (dig_ok) begin
      if (same) stab_nxt = (stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1;
      else      stab_nxt = 4'd1;
    end
  end

  // accept only on the transition into STAB so a long stable run fires once
  assign fire = dig_ok && (stab_nxt == STAB) && (!same || (stab_cnt != STAB));

  assign frame_hit = ((prog & MASK) == MASK);

  // completed frame clears first; a coincident accept lands in the next frame
  always_comb begin
    prog_nxt = frame_hit ? '0 : prog;
    if (trip)
      prog_nxt = '0;
    else if (fire && g_legal)
      prog_nxt[dig_k] = 1'b1;
  end

  seg7_glyph_decode u_glyph (
    .pat   (s[6:0]),
    .val   (g_val),
    .legal (g_legal)
  );

  // sync stages, counters, FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s          <= '0;
      state      <= ST_OFF;
      stab_cnt   <= '0;
      off_cnt    <= '0;
      cand_vld   <= 1'b0;
      cand_k     <= '0;
      cand_pat   <= '0;
      prog       <= '0;
      digits     <= '0;
      dig_valid  <= '0;
      dp         <= '0;
      code_err   <= '0;
      frame_done <= 1'b0;
      disp_off   <= 1'b1;
    end else begin
      s1         <= segf;
      s          <= s1;
      off_cnt    <= (s != '0) ? 8'd0 : ((off_cnt == 8'hFF) ? off_cnt : off_cnt + 8'd1);
      stab_cnt   <= stab_nxt;
      cand_vld   <= dig_ok;
      cand_k     <= dig_k;
      cand_pat   <= s[7:0];
      prog       <= prog_nxt;
      frame_done <= frame_hit;
      if (trip) begin
        disp_off  <= 1'b1;
        dig_valid <= '0;
        state     <= ST_OFF;
      end else begin
        case (state)
          ST_OFF: begin
            if (dig_ok) begin
              disp_off <= 1'b0;
              state    <= fire ? ST_ACCEPT : ST_SCAN;
            end
          end
          default: state <= fire ? ST_ACCEPT : ST_SCAN;
        endcase
        if (fire) begin
          if (g_legal) begin
            digits[{dig_k, 2'b00} +: 4] <= g_val;
            dp[dig_k]                   <= ~s[DP_BIT];
            dig_valid[dig_k]            <= 1'b1;
          end else begin
            code_err[dig_k] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
